// File: rtl/i2c_target_regif_if.sv
// Bus-side pins and register-file port of the I2C target, grouped for port connection.
interface i2c_target_regif_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              scl_i;
    logic              sda_i;
    logic              sda_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr;
    logic [7:0]        reg_wdata;
    logic              reg_rd;
    logic [7:0]        reg_rdata;
    logic              busy;
    logic              addressed;

    modport slave (
        input  scl_i, sda_i, reg_rdata,
        output sda_oe, reg_addr, reg_wr, reg_wdata, reg_rd, busy, addressed
    );

    modport master (
        output scl_i, sda_i, reg_rdata,
        input  sda_oe, reg_addr, reg_wr, reg_wdata, reg_rd, busy, addressed
    );
endinterface

// File: rtl/i2c_target_regif.sv
// I2C target: filters the bus pins, decodes START/STOP/address/data and bridges
// write/read transfers onto a synchronous register-file port through an auto-incrementing pointer.
module i2c_target_regif #(
    parameter logic [6:0]  SLV_ADR  = 7'h50,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned ADDR_W   = 8
) (
    input logic               clk,
    input logic               rstn,
    i2c_target_regif_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    // index 0 = SCL, index 1 = SDA; idle bus level is high
    logic [1:0]            sync1, sync2, filt, filt_p;
    logic [1:0][CNT_W-1:0] fcnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_p <= 2'b11;
            fcnt   <= '0;
        end else begin
            sync1  <= {bus.sda_i, bus.scl_i};
            sync2  <= sync1;
            filt_p <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CNT_W'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c, sda_f;
    assign sda_f    = filt[1];
    assign scl_rise = filt[0] & ~filt_p[0];
    assign scl_fall = ~filt[0] & filt_p[0];
    assign start_c  = filt[0] & filt_p[0] & filt_p[1] & ~filt[1];
    assign stop_c   = filt[0] & filt_p[0] & ~filt_p[1] & filt[1];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        sh_q, sh_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d, oe_q, oe_d, wr_q, wr_d, rd_q, rd_d;
    logic              rdp_q, rdp_d, busy_q, busy_d, adr_q, adr_d;
    logic              cnt8, adr_match;

    assign cnt8      = (cnt_q == CNT_W'(8));
    assign adr_match = (sh_q[7:1] == SLV_ADR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            rw_q    <= 1'b0;
            oe_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rdp_q   <= 1'b0;
            busy_q  <= 1'b0;
            adr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            oe_q    <= oe_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rdp_q   <= rdp_d;
            busy_q  <= busy_d;
            adr_q   <= adr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = S_ADDR;
        end else if (stop_c) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR:      if (scl_fall && cnt8) state_d = adr_match ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:  if (scl_fall) state_d = rw_q ? S_RDATA : S_PTR;
                S_PTR:       if (scl_fall && cnt8) state_d = S_PTR_ACK;
                S_PTR_ACK:   if (scl_fall) state_d = S_WDATA;
                S_WDATA:     if (scl_fall && cnt8) state_d = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_fall) state_d = S_WDATA;
                S_RDATA:     if (scl_fall && cnt8) state_d = S_RDATA_ACK;
                S_RDATA_ACK: begin
                    if (scl_rise && sda_f) state_d = S_IGNORE;
                    else if (scl_fall)     state_d = S_RDATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        oe_d    = oe_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        rdp_d   = rd_q;
        busy_d  = busy_q;
        adr_d   = adr_q;
        // read data arrives one clk after the strobe
        if (rdp_q) sh_d = bus.reg_rdata;
        if (start_c) begin
            cnt_d  = '0;
            oe_d   = 1'b0;
            busy_d = 1'b1;
            adr_d  = 1'b0;
            rdp_d  = 1'b0;
        end else if (stop_c) begin
            oe_d   = 1'b0;
            busy_d = 1'b0;
            adr_d  = 1'b0;
            rdp_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        sh_d  = {sh_q[6:0], sda_f};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == S_WDATA && cnt_q == CNT_W'(7)) begin
                            wr_d    = 1'b1;
                            wdata_d = {sh_q[6:0], sda_f};
                        end
                    end else if (scl_fall && cnt8) begin
                        if (state_q == S_ADDR) begin
                            if (adr_match) begin
                                oe_d  = 1'b1;
                                adr_d = 1'b1;
                                rw_d  = sh_q[0];
                                rd_d  = sh_q[0];
                            end
                        end else begin
                            oe_d = 1'b1;
                            if (state_q == S_PTR) ptr_d = ADDR_W'(sh_q);
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        oe_d  = 1'b0;
                        if (state_q == S_WDATA_ACK) ptr_d = ptr_q + ADDR_W'(1);
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            oe_d  = ~sh_q[7];
                            sh_d  = {sh_q[6:0], 1'b0};
                            cnt_d = CNT_W'(1);
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (cnt8) begin
                            oe_d = 1'b0;
                        end else begin
                            oe_d  = ~sh_q[7];
                            sh_d  = {sh_q[6:0], 1'b0};
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise && !sda_f) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        rd_d  = 1'b1;
                    end else if (scl_fall) begin
                        oe_d  = ~sh_q[7];
                        sh_d  = {sh_q[6:0], 1'b0};
                        cnt_d = CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe    = oe_q;
    assign bus.reg_addr  = ptr_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_rd    = rd_q;
    assign bus.busy      = busy_q;
    assign bus.addressed = adr_q;
endmodule
